// File: rtl/bin_to_bcd_seq_v_if.sv
// Handshake bundle for the sequential binary-to-BCD converter.
// master: the calculator/display side driving values in and accepting results.
// slave : the converter itself.
interface bin_to_bcd_seq_v_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  i_valid;
    logic [WIDTH-1:0]      i_bin;
    logic                  o_ready;
    logic                  o_valid;
    logic                  i_ready;
    logic [4*DIGITS-1:0]   o_bcd;
    logic                  o_busy;

    modport master (
        output i_valid, i_bin, i_ready,
        input  o_ready, o_valid, o_bcd, o_busy
    );

    modport slave (
        input  i_valid, i_bin, i_ready,
        output o_ready, o_valid, o_bcd, o_busy
    );
endinterface

// File: rtl/bin_to_bcd_seq_v.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock).
// A value is captured in IDLE, shifted WIDTH times in SHIFT, then held in DONE
// until downstream takes it. Only one conversion is in flight at a time.
module bin_to_bcd_seq_v #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    bin_to_bcd_seq_v_if.slave  bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [BW-1:0]   bcd_q;
    logic [WIDTH-1:0] bin_q;
    logic [BW-1:0]   bcd_out_q;
    logic            valid_q;

    logic [BW-1:0]       bcd_adj;
    logic [BW+WIDTH-1:0] shifted;
    logic [BW-1:0]       next_bcd;
    logic [WIDTH-1:0]    next_bin;
    logic                ready;
    logic                busy;

    // Add-3 to every digit that is 5 or more, then shift {bcd,bin} left by one.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so no latch is inferred.
        bcd_adj = bcd_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
            end
        end
        shifted  = {bcd_adj, bin_q} << 1;
        next_bcd = shifted[BW+WIDTH-1 -: BW];
        next_bin = shifted[WIDTH-1:0];
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

    // Next-state and status outputs; o_ready is held low while reset is asserted.
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        busy    = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready = ~i_rst;
                if (bus.i_valid) state_d = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt_q == LAST) state_d = DONE;
            end
            DONE: begin
                if (bus.i_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: capture, iterate, publish the finished digits, and retire on handoff.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q     <= '0;
            bcd_q     <= '0;
            bin_q     <= '0;
            bcd_out_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.i_valid) begin
                        bin_q <= bus.i_bin;
                        bcd_q <= '0;
                        cnt_q <= '0;
                    end
                end
                SHIFT: begin
                    bcd_q <= next_bcd;
                    bin_q <= next_bin;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        bcd_out_q <= next_bcd;
                        valid_q   <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.i_ready) valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_ready = ready;
    assign bus.o_busy  = busy;
    assign bus.o_valid = valid_q;
    assign bus.o_bcd   = bcd_out_q;
endmodule

// File: tb/tb_bin_to_bcd_seq_v.sv
// Randomised and directed bench for bin_to_bcd_seq_v against a decimal-arithmetic model.
module tb_bin_to_bcd_seq_v;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    bin_to_bcd_seq_v_if #(.WIDTH(8), .DIGITS(3)) bus ();

    bin_to_bcd_seq_v #(.WIDTH(8), .DIGITS(3)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal digits by plain division.
    function automatic logic [11:0] model_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Drive one conversion from IDLE; reports result, latency, hold and handoff behaviour.
    task automatic run_one(input logic [7:0] v, input int stall,
                           output logic [11:0] got, output int lat,
                           output bit held_ok, output bit dropped,
                           output logic [11:0] after);
        bus.i_ready = (stall == 0);
        bus.i_valid = 1'b1;
        bus.i_bin   = v;
        @(posedge clk); @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_bin   = 8'($urandom);
        lat = 0;
        while (!bus.o_valid && lat < 40) begin
            @(posedge clk); @(negedge clk);
            lat++;
        end
        got     = bus.o_bcd;
        held_ok = 1'b1;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); @(negedge clk);
            if (bus.o_valid !== 1'b1 || bus.o_bcd !== got) held_ok = 1'b0;
        end
        bus.i_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        dropped = (bus.o_valid === 1'b0);
        after   = bus.o_bcd;
    endtask

    task automatic test_reset();
        #2;
        total++; if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", bus.o_ready); end
        total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.o_valid); end
        total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
        total++; if (bus.o_bcd !== 12'h000) begin bad++; $display("FAIL reset_bcd: got %h want 000", bus.o_bcd); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL release_ready: got %b want 1", bus.o_ready); end
        @(negedge clk);
    endtask

    task automatic test_known();
        logic [7:0]  vals [5] = '{8'd195, 8'd0, 8'd255, 8'd9, 8'hD3};
        logic [11:0] got, after, exp;
        int          lat;
        bit          held_ok, dropped;
        foreach (vals[k]) begin
            exp = model_bcd(int'(vals[k]));
            run_one(vals[k], 0, got, lat, held_ok, dropped, after);
            total++; if (got !== exp) begin bad++; $display("FAIL known_bcd[%0d]: got %h want %h", vals[k], got, exp); end
            total++; if (lat != 8) begin bad++; $display("FAIL known_latency[%0d]: got %0d want 8", vals[k], lat); end
            total++; if (!dropped) begin bad++; $display("FAIL known_pulse[%0d]: o_valid got 1 want 0 after one cycle", vals[k]); end
        end
    endtask

    task automatic test_backpressure();
        logic [11:0] got, after;
        int          lat;
        bit          held_ok, dropped;
        run_one(8'd100, 5, got, lat, held_ok, dropped, after);
        total++; if (got !== 12'h100) begin bad++; $display("FAIL bp_bcd: got %h want 100", got); end
        total++; if (!held_ok) begin bad++; $display("FAIL bp_hold: held got 0 want 1"); end
        total++; if (!dropped) begin bad++; $display("FAIL bp_release: dropped got 0 want 1"); end
        total++; if (after !== 12'h100) begin bad++; $display("FAIL bp_retain: got %h want 100", after); end
    endtask

    task automatic test_ignore_busy();
        int n = 0;
        bit ready_low = 1'b1;
        bit busy_high = 1'b1;
        bus.i_ready = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_bin   = 8'd42;
        @(posedge clk); @(negedge clk);
        bus.i_bin = 8'd77;
        while (!bus.o_valid && n < 40) begin
            if (bus.o_ready !== 1'b0) ready_low = 1'b0;
            if (bus.o_busy !== 1'b1) busy_high = 1'b0;
            @(posedge clk); @(negedge clk);
            n++;
        end
        total++; if (n != 8) begin bad++; $display("FAIL ign_latency: got %0d want 8", n); end
        total++; if (!ready_low) begin bad++; $display("FAIL ign_ready: ready low got 0 want 1"); end
        total++; if (!busy_high) begin bad++; $display("FAIL ign_busy: busy high got 0 want 1"); end
        total++; if (bus.o_bcd !== 12'h042) begin bad++; $display("FAIL ign_bcd: got %h want 042", bus.o_bcd); end
        total++; if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL ign_done_ready: got %b want 0", bus.o_ready); end
        bus.i_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL ign_drop: got %b want 0", bus.o_valid); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int gap = 0;
        logic [7:0] v = 8'($urandom);
        bus.i_ready = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_bin   = v;
        while (!bus.o_valid && n < 40) begin
            @(posedge clk); @(negedge clk);
            n++;
        end
        total++; if (!bus.o_valid) begin bad++; $display("FAIL b2b_first: timeout after %0d cycles", n); end
        do begin
            @(posedge clk); @(negedge clk);
            gap++;
        end while (!bus.o_valid && gap < 40);
        total++; if (gap != 10) begin bad++; $display("FAIL b2b_gap: got %0d want 10", gap); end
        total++; if (bus.o_bcd !== model_bcd(int'(v))) begin bad++; $display("FAIL b2b_bcd: got %h want %h", bus.o_bcd, model_bcd(int'(v))); end
        bus.i_valid = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit quiet = 1'b1;
        bus.i_ready = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_bin   = 8'd150;
        @(posedge clk); @(negedge clk);
        bus.i_valid = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        #1;
        total++; if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL mid_ready: got %b want 0", bus.o_ready); end
        total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", bus.o_busy); end
        total++; if (bus.o_bcd !== 12'h000) begin bad++; $display("FAIL mid_bcd: got %h want 000", bus.o_bcd); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL mid_release_ready: got %b want 1", bus.o_ready); end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0) quiet = 1'b0;
        end
        total++; if (!quiet) begin bad++; $display("FAIL mid_no_pulse: quiet got 0 want 1"); end
    endtask

    task automatic test_random();
        logic [11:0] got, after, exp;
        int          lat;
        bit          held_ok, dropped;
        int          errs = 0;
        for (int k = 0; k < 40; k++) begin
            logic [7:0] v = 8'($urandom);
            int stall = int'($urandom_range(0, 3));
            exp = model_bcd(int'(v));
            run_one(v, stall, got, lat, held_ok, dropped, after);
            total++;
            if (got !== exp || lat != 8 || !held_ok || !dropped || after !== exp) begin
                bad++;
                $display("FAIL rand[%0d] v=%0d: got %h lat %0d hold %b drop %b keep %h want %h lat 8 hold 1 drop 1",
                         k, v, got, lat, held_ok, dropped, after, exp);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        errs = 0;
    endtask

    initial begin
        rst         = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_bin   = '0;
        bus.i_ready = 1'b1;
        test_reset();
        test_known();
        test_backpressure();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
